// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
//   Arbitrates NUM_PORTS cache requesters onto one multi-cycle main memory.
//   A read miss becomes a whole-block fill of BLOCK_WORDS words. A store is
//   sent through as one word. Each fill word is returned with its index in
//   the block and with the owning port.
//
//   Optional feature macro: MEM_FILL_ARB_RR_EN
//     defined   : round-robin arbitration. A pointer holds the last owner + 1
//                 and the first set req at or after the pointer wins.
//     undefined : fixed priority, port 0 highest.
//
//   Ports
//     clk, rst          clock (rising edge), asynchronous active-low reset
//     req/req_wr        per-port request level and write flag
//     req_addr/wdata    per-port address / write data, port p at [p*W +: W]
//     grant             one-hot owner while busy
//     done              one-cycle pulse to the owner at the end of service
//     rvalid/rdata/rword  fill word strobe (per port), data and block index
//     busy              arbiter not idle
//     mem_*             main memory request, read data and read-data valid
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | no owner; arbitrate and latch the winning request
//   S_FILL  | issue BLOCK_WORDS reads and collect the returned words
//   S_WRITE | single write cycle to memory
//   S_DONE  | done pulse to owner; release grant
module mem_fill_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_STRIDE = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [NUM_PORTS-1:0]            done,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [DATA_W-1:0]               rdata,
    output logic [$clog2(BLOCK_WORDS)-1:0]  rword,
    output logic                            busy,
    output logic                            mem_enable,
    output logic                            mem_wr,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            mem_data_valid
);

    localparam int OW  = $clog2(NUM_PORTS);
    localparam int OW1 = OW + 1;
    localparam int WW  = $clog2(BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BLOCK_WORDS * ADDR_STRIDE - 1);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(ADDR_STRIDE);
    localparam logic [WW-1:0]     LAST_WORD  = WW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [WW-1:0]   issue_cnt;
    logic [WW-1:0]   recv_cnt;

    logic [OW-1:0]   win_idx;
    logic            win_found;
    logic            sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic            fill_valid;

`ifdef MEM_FILL_ARB_RR_EN
    logic [OW-1:0]        rr_ptr;
    logic [NUM_PORTS-1:0] req_rot;
    logic [OW1-1:0]       rot_idx;
    logic [OW1-1:0]       rot_sum;

    // Rotate the request vector so the pointer position sits at bit 0, pick
    // the lowest set bit, then map it back to a port number mod NUM_PORTS.
    always_comb begin
        req_rot   = NUM_PORTS'({req, req} >> rr_ptr);
        rot_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx   = OW1'(i);
                win_found = 1'b1;
            end
        end
        rot_sum = {1'b0, rr_ptr} + rot_idx;
        if (rot_sum >= OW1'(NUM_PORTS)) begin
            rot_sum = rot_sum - OW1'(NUM_PORTS);
        end
        win_idx = OW'(rot_sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (state == S_DONE) begin
            rr_ptr <= (owner == OW'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
        end
    end
`else
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx   = OW'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win_idx == OW'(i)) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Fill data is forwarded with zero latency; valids outside FILL are dropped.
    assign fill_valid = (state == S_FILL) && mem_data_valid;
    assign rvalid     = fill_valid ? grant     : '0;
    assign rdata      = fill_valid ? mem_rdata : '0;
    assign rword      = fill_valid ? recv_cnt  : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done       <= '0;
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                    if (win_found) begin
                        owner      <= win_idx;
                        grant      <= NUM_PORTS'(1) << win_idx;
                        busy       <= 1'b1;
                        mem_enable <= 1'b1;
                        issue_cnt  <= '0;
                        recv_cnt   <= '0;
                        if (sel_wr) begin
                            state     <= S_WRITE;
                            mem_wr    <= 1'b1;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end else begin
                            state    <= S_FILL;
                            mem_addr <= sel_addr & ~ALIGN_MASK;
                        end
                    end
                end
                S_FILL: begin
                    // Issue and receive run independently so any latency works.
                    if (mem_enable) begin
                        if (issue_cnt == LAST_WORD) begin
                            mem_enable <= 1'b0;
                        end else begin
                            issue_cnt <= issue_cnt + 1'b1;
                            mem_addr  <= mem_addr + STRIDE;
                        end
                    end
                    if (mem_data_valid) begin
                        if (recv_cnt == LAST_WORD) begin
                            state <= S_DONE;
                            done  <= NUM_PORTS'(1) << owner;
                        end else begin
                            recv_cnt <= recv_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                    state      <= S_DONE;
                    done       <= NUM_PORTS'(1) << owner;
                end
                S_DONE: begin
                    done       <= '0;
                    grant      <= '0;
                    busy       <= 1'b0;
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Testbench for mem_fill_arbiter: behavioural memory with configurable
// latency and stalls, scoreboard queues filled when requests are driven.
module tb_mem_fill_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, req_wr;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      grant, done, rvalid;
    logic [DW-1:0]     rdata;
    logic [2:0]        rword;
    logic              busy, mem_enable, mem_wr;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;
    logic              mem_data_valid;

    mem_fill_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW),
                       .BLOCK_WORDS(8), .ADDR_STRIDE(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rvalid(rvalid), .rdata(rdata),
        .rword(rword), .busy(busy), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int port; int w; logic [15:0] d; } word_t;
    typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
    typedef struct { int port; bit is_wr; } done_t;

    word_t       exp_word[$];
    logic [15:0] exp_addr[$];
    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [15:0] pend_addr[$];
    int          pend_cyc[$];

    int errors = 0, checks = 0;
    int cyc = 0, lat = 1, stall_at = -1, stall_left = 0;
    int deliv_total = 0, rx_total = 0;
    int last_wr_cyc = -10, last_done_cyc = -10;
    int model_ptr = 0;
    bit spur_req = 0;
    logic [N-1:0] prev_grant = '0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory model and output monitor.
    initial begin
        word_t wx; wr_t wy; done_t dx;
        mem_data_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (mem_enable && !mem_wr) begin
                    pend_addr.push_back(mem_addr);
                    pend_cyc.push_back(cyc);
                    if (exp_addr.size() == 0) check_val("issue_extra", mem_enable, 0);
                    else check_val("issue_addr", mem_addr, exp_addr.pop_front());
                end
                if (mem_enable && mem_wr) begin
                    last_wr_cyc = cyc;
                    if (exp_wr.size() == 0) check_val("write_extra", mem_wr, 0);
                    else begin
                        wy = exp_wr.pop_front();
                        check_val("write_addr", mem_addr, wy.a);
                        check_val("write_data", mem_wdata, wy.d);
                    end
                end
                if (grant != 0 && exp_done.size() != 0)
                    check_val("grant_owner", grant, N'(1) << exp_done[0].port);
                if (grant != 0 && prev_grant == 0)
                    check_val("idle_gap", (cyc - last_done_cyc) >= 2, 1);
                if (done != 0) begin
                    if (exp_done.size() == 0) check_val("done_extra", done, 0);
                    else begin
                        dx = exp_done.pop_front();
                        check_val("done_port", done, N'(1) << dx.port);
                        check_val("done_busy", busy, 1);
                        if (dx.is_wr) check_val("done_after_wr", cyc - last_wr_cyc, 1);
                    end
                    last_done_cyc = cyc;
                end
                prev_grant = grant;
            end
            mem_data_valid = 1'b0;
            mem_rdata      = 16'hDEAD;
            if (spur_req) begin
                mem_data_valid = 1'b1;
                mem_rdata      = 16'h5555;
            end else if (pend_addr.size() != 0 && cyc >= pend_cyc[0] + lat) begin
                if (stall_at >= 0 && deliv_total == stall_at && stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_data_valid = 1'b1;
                    mem_rdata      = mem_fn(pend_addr.pop_front());
                    void'(pend_cyc.pop_front());
                    deliv_total++;
                end
            end
            #1;
            if (rvalid != 0) begin
                if (exp_word.size() == 0) check_val("rvalid_extra", rvalid, 0);
                else begin
                    wx = exp_word.pop_front();
                    check_val("rvalid_port", rvalid, N'(1) << wx.port);
                    check_val("rword", rword, wx.w);
                    check_val("rdata", rdata, wx.d);
                end
                rx_total++;
            end
            if (spur_req) begin
                check_val("spur_rvalid", rvalid, 0);
                check_val("spur_busy", busy, 0);
                spur_req = 0;
            end
        end
    end

    task automatic push_service(input int p, input bit wr, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] wa;
        if (wr) exp_wr.push_back('{a: a, d: d});
        else begin
            for (int w = 0; w < 8; w++) begin
                wa = (a & 16'hFFF0) + 16'(w * 2);
                exp_addr.push_back(wa);
                exp_word.push_back('{port: p, w: w, d: mem_fn(wa)});
            end
        end
        exp_done.push_back('{port: p, is_wr: wr});
    endtask

    task automatic flush_sb();
        exp_word.delete(); exp_addr.delete(); exp_wr.delete(); exp_done.delete();
    endtask

    // Drive a set of simultaneous requests and wait until all are served.
    task automatic serve(input logic [N-1:0] mask, input logic [N-1:0] wr_mask,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        logic [N-1:0] rem;
        int p;
        rem = mask;
        while (rem != 0) begin
            p = -1;
`ifdef MEM_FILL_ARB_RR_EN
            for (int k = 0; k < N; k++)
                if (p < 0 && rem[(model_ptr + k) % N]) p = (model_ptr + k) % N;
`else
            for (int k = 0; k < N; k++)
                if (p < 0 && rem[k]) p = k;
`endif
            push_service(p, wr_mask[p], (p == 0) ? a0 : a1, (p == 0) ? d0 : d1);
            model_ptr = (p + 1) % N;
            rem[p] = 1'b0;
        end
        @(negedge clk); #2;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        req_wr    = wr_mask;
        req       = mask;
        for (int t = 0; t < 2000 && req != 0; t++) begin
            @(negedge clk); #2;
            req = req & ~done;
        end
        if (req != 0) begin
            check_val("timeout", req, 0);
            req = '0;
        end
        @(negedge clk); #2;
        check_val("busy_idle", busy, 0);
        check_val("sb_empty", exp_word.size() + exp_addr.size() + exp_wr.size() + exp_done.size(), 0);
        flush_sb();
    endtask

    initial begin
        int start, t;
        rst = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        #1;
        check_val("reset_outs", {grant, done, rvalid, busy, mem_enable, mem_wr,
                                 mem_addr, mem_wdata, rdata, rword}, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        serve(2'b10, 2'b00, 16'h0000, 16'h1236, 16'h0, 16'h0);       // port 1 fill
        serve(2'b11, 2'b00, 16'h2000, 16'h3008, 16'h0, 16'h0);       // simultaneous pair
        serve(2'b10, 2'b10, 16'h0000, 16'h00A4, 16'h0, 16'hBEEF);    // port 1 write
        serve(2'b01, 2'b01, 16'h0010, 16'h0000, 16'h1234, 16'h0);    // port 0 write
        serve(2'b11, 2'b00, 16'h5000, 16'h6002, 16'h0, 16'h0);       // second pair

        lat = 4; stall_at = deliv_total + 4; stall_left = 3;           // latency + stall
        serve(2'b01, 2'b00, 16'h0A0C, 16'h0000, 16'h0, 16'h0);
        stall_at = -1; lat = 1;

        @(negedge clk); #2 spur_req = 1;                               // spurious valid
        repeat (3) @(negedge clk);

        // Reset in the middle of a fill.
        lat = 2;
        push_service(0, 1'b0, 16'h4006, 16'h0);
        start = rx_total;
        @(negedge clk); #2;
        req_addr = {16'h0, 16'h4006}; req_wr = '0; req = 2'b01;
        t = 0;
        while (t < 500 && rx_total < start + 3) begin
            @(negedge clk); #2; t++;
        end
        check_val("rst_words_seen", rx_total - start, 3);
        rst = 1'b0;
        #1;
        check_val("rst_async_outs", {grant, done, rvalid, busy, mem_enable, mem_wr,
                                     mem_addr, mem_wdata, rdata, rword}, 0);
        flush_sb();
        req = '0;
        model_ptr = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (15) @(negedge clk);
        #2 check_val("rst_busy", busy, 0);
        lat = 1;

        serve(2'b10, 2'b00, 16'h0000, 16'hFFF8, 16'h0, 16'h0);       // fill after reset
        serve(2'b11, 2'b01, 16'h0102, 16'h7FFA, 16'hA5A5, 16'h0);    // write + fill pair

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got t=%0t expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
